// File: rtl/regfile_sb.sv
// regfile_sb: register file with one write port, two async read ports and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy clear onto the read ports.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    RegWrite,
    input  logic [ADDR_W-1:0]       WriteRegister,
    input  logic [DATA_W-1:0]       WriteData,
    input  logic [ADDR_W-1:0]       ReadRegister1,
    input  logic [ADDR_W-1:0]       ReadRegister2,
    output logic [DATA_W-1:0]       ReadData1,
    output logic [DATA_W-1:0]       ReadData2,
    input  logic                    IssueValid,
    input  logic [ADDR_W-1:0]       IssueRegister,
    output logic                    Busy1,
    output logic                    Busy2,
    output logic [(2**ADDR_W)-1:0]  WriteEn
);
    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   regFile [NUM_REGS];
    logic [NUM_REGS-1:0] busyBits;
    logic [NUM_REGS-1:0] issueVec;
    logic                zero1;
    logic                zero2;

    always_comb begin
        WriteEn = '0;
        issueVec = '0;
        if (RegWrite) WriteEn[WriteRegister] = 1'b1;
        if (IssueValid) issueVec[IssueRegister] = 1'b1;
        if (ZERO_REG != 0) begin
            WriteEn[0] = 1'b0;
            issueVec[0] = 1'b0;
        end
    end

    // A new producer issued on the same edge as a writeback keeps the register busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
            busyBits <= '0;
        end else begin
            if (|WriteEn) regFile[WriteRegister] <= WriteData;
            busyBits <= issueVec | (busyBits & ~WriteEn);
        end
    end

    assign zero1 = (ZERO_REG != 0) && (ReadRegister1 == '0);
    assign zero2 = (ZERO_REG != 0) && (ReadRegister2 == '0);

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        ReadData1 = WriteEn[ReadRegister1] ? WriteData : zero1 ? '0 : regFile[ReadRegister1];
        ReadData2 = WriteEn[ReadRegister2] ? WriteData : zero2 ? '0 : regFile[ReadRegister2];
        Busy1 = WriteEn[ReadRegister1] ? issueVec[ReadRegister1] : busyBits[ReadRegister1] & ~zero1;
        Busy2 = WriteEn[ReadRegister2] ? issueVec[ReadRegister2] : busyBits[ReadRegister2] & ~zero2;
    end
`else
    always_comb begin
        ReadData1 = zero1 ? '0 : regFile[ReadRegister1];
        ReadData2 = zero2 ? '0 : regFile[ReadRegister2];
        Busy1 = busyBits[ReadRegister1] & ~zero1;
        Busy2 = busyBits[ReadRegister2] & ~zero2;
    end
`endif
endmodule
